bin_to_bcd_seq: RTL



---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_add3.sv | 19 +
 rtl/bin_to_bcd_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Brief  : Shared constants and state encoding for the binary-to-BCD path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int          DIGIT_W     = 4;
    localparam logic [3:0]  BLANK_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// ============================================================================
// Module : bcd_add3
// Brief  : Per-nibble double-dabble correction: adds 3 when the digit is >= 5.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] nib_in,
    output logic [DIGIT_W-1:0] nib_out
);

    assign nib_out = (nib_in >= DIGIT_W'(5)) ? nib_in + DIGIT_W'(3) : nib_in;

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// Module : bin_to_bcd_seq
// Brief  : Sequential double-dabble converter, one bit per clock, with
//          leading-zero blanking and overflow masking for 7-segment display.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W    = 14,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic [4*DIGITS-1:0]     bcd_out
);

    localparam int                  c_scr_w   = DIGIT_W * DIGITS;
    localparam int                  c_cnt_w   = $clog2(BIN_W + 1);
    localparam longint              c_lim     = longint'(10 ** DIGITS) - 1;
    // When the display range exceeds what BIN_W can encode, overflow is impossible.
    localparam bit                  c_fits    = c_lim < (longint'(1) << BIN_W);
    localparam logic [BIN_W-1:0]    c_max_val = BIN_W'(c_lim);
    localparam logic [c_scr_w-1:0]  c_blank   = {DIGITS{BLANK_DIGIT}};

    state_t                 r_state;
    logic [BIN_W-1:0]       r_bin;
    logic [c_scr_w-1:0]     r_scr;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_ovf_pend;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ovf;
    logic [c_scr_w-1:0]     r_bcd;

    logic [c_scr_w-1:0]     w_adj;
    logic [c_scr_w-1:0]     w_disp;
    logic                   w_lead;
    logic                   w_ovf_in;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .nib_in  (r_scr[gi*DIGIT_W +: DIGIT_W]),
                .nib_out (w_adj[gi*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    assign w_ovf_in = c_fits && (bin > c_max_val);

    // Blank zeros from the top digit down until the first nonzero; digit 0 always shows.
    always_comb begin
        w_disp = r_scr;
        w_lead = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            if ((BLANK_LZ != 0) && w_lead && (r_scr[k*DIGIT_W +: DIGIT_W] == '0)) begin
                w_disp[k*DIGIT_W +: DIGIT_W] = BLANK_DIGIT;
            end else begin
                w_lead = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_bin      <= '0;
            r_scr      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_bcd      <= c_blank;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bin      <= bin;
                        r_scr      <= '0;
                        r_cnt      <= c_cnt_w'(BIN_W);
                        r_ovf_pend <= w_ovf_in;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {r_scr, r_bin} <= {w_adj, r_bin} << 1;
                    r_cnt          <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bcd   <= r_ovf_pend ? c_blank : w_disp;
                    r_ovf   <= r_ovf_pend;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign ovf     = r_ovf;
    assign bcd_out = r_bcd;

endmodule

`default_nettype wire
